// File: rtl/io_pkg.sv
// -----------------------------------------------------------------------------
// io_pkg
// Shared definitions for the memory-mapped switch/key/LED port bank.
// Holds the register index map (word index taken from addr[6:2]) used by
// io_port_bank and by anything that decodes the IO window.
// -----------------------------------------------------------------------------
package io_pkg;

    // Word index inside the IO window (addr[6:2]).
    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t IDX_IN     = 5'd0;
    localparam reg_idx_t IDX_OUT    = 5'd8;
    localparam reg_idx_t IDX_STATUS = 5'd16;
    localparam reg_idx_t IDX_IEN    = 5'd17;

    // Index of output/input register k relative to a bank base.
    function automatic reg_idx_t bank_idx(input reg_idx_t base, input int k);
        return base + reg_idx_t'(k);
    endfunction

endpackage

// File: rtl/io_port_bank_if.sv
// -----------------------------------------------------------------------------
// io_port_bank_if
// CPU-side data-memory bus into the IO port bank.
//   addr  : byte address (addr[7] selects the IO window, addr[6:2] the register)
//   wdata : store data
//   we    : store strobe
//   rdata : read data for the addressed register (combinational)
// master = CPU / memory system, slave = io_port_bank.
// -----------------------------------------------------------------------------
interface io_port_bank_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;

    modport master (output addr, output wdata, output we, input rdata);
    modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/io_debounce.sv
// -----------------------------------------------------------------------------
// io_debounce
// One input port: 2-flop synchroniser, stability counter and debounced register.
//   clock   : sole clock
//   resetn  : asynchronous active-low reset
//   din     : raw asynchronous input (W bits)
//   dout    : debounced value (registered)
//   changed : high for the cycle in which dout is about to take a new value
// A change of din appears on dout exactly 2+DEB_CYCLES clocks later, provided
// it stays stable; shorter glitches are discarded.
// -----------------------------------------------------------------------------
module io_debounce #(
    parameter int W          = 4,
    parameter int DEB_CYCLES = 16
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         changed
);

    localparam int CNT_W = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic [W-1:0]     sync1_r;
    logic [W-1:0]     sync2_r;
    logic [W-1:0]     deb_r;
    logic [CNT_W-1:0] cnt_r;
    logic             load_s;

    // Two-flop synchroniser for the raw asynchronous input.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1_r <= {W{1'b0}};
            sync2_r <= {W{1'b0}};
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
        end
    end

    // Stability counter: sync1_r is the next synchronised sample, so a
    // mismatch with sync2_r means the synchronised value is changing now.
    // Saturates at DEB_CYCLES-1 and never wraps.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (sync1_r != sync2_r) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Load decision: synchronised value stable for DEB_CYCLES edges and new.
    always_comb begin
        load_s = (cnt_r == CNT_MAX) && (sync2_r != deb_r);
    end

    // Debounced register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            deb_r <= {W{1'b0}};
        end else if (load_s) begin
            deb_r <= sync2_r;
        end else begin
            deb_r <= deb_r;
        end
    end

    assign dout    = deb_r;
    assign changed = load_s;

endmodule

// File: rtl/io_port_bank.sv
// -----------------------------------------------------------------------------
// io_port_bank
// Memory-mapped IO bank: debounced input ports, 32-bit output registers,
// change-status flags with interrupt enable and a level interrupt.
//   clock    : sole clock
//   resetn   : asynchronous active-low reset
//   bus      : CPU data bus (io_port_bank_if.slave); rdata is combinational
//   in_port  : raw inputs, port k at [k*IN_W +: IN_W]
//   out_port : output registers, port k at [k*32 +: 32]
//   irq      : registered OR of (STATUS & IEN)
// Register map (addr[6:2], only when addr[7]=1):
//   0..NUM_IN-1   IN[k]   RO  debounced value, zero-extended
//   8..8+NUM_OUT-1 OUT[k] RW
//   16            STATUS  W1C change flags (set wins over clear)
//   17            IEN     RW  interrupt enable per input port
//   others read 0, writes ignored.
// -----------------------------------------------------------------------------
module io_port_bank
    import io_pkg::*;
#(
    parameter int NUM_IN     = 2,
    parameter int IN_W       = 4,
    parameter int NUM_OUT    = 3,
    parameter int DEB_CYCLES = 16
) (
    input  logic                    clock,
    input  logic                    resetn,
    io_port_bank_if.slave           bus,
    input  logic [NUM_IN*IN_W-1:0]  in_port,
    output logic [NUM_OUT*32-1:0]   out_port,
    output logic                    irq
);

    logic                   io_sel_s;
    reg_idx_t               idx_s;
    logic                   wr_s;
    logic                   unused_addr_s;
    logic [NUM_IN*IN_W-1:0] deb_s;
    logic [NUM_IN-1:0]      chg_s;
    logic [NUM_IN-1:0]      status_r;
    logic [NUM_IN-1:0]      ien_r;
    logic [NUM_IN-1:0]      clr_s;
    logic                   ien_wr_s;
    logic                   irq_r;
    logic [31:0]            rd_s;

    assign io_sel_s      = bus.addr[7];
    assign idx_s         = bus.addr[6:2];
    assign wr_s          = bus.we && io_sel_s;
    assign unused_addr_s = ^{bus.addr[31:8], bus.addr[1:0]};

    // Per-port synchroniser + debouncer.
    for (genvar g = 0; g < NUM_IN; g++) begin : g_in
        io_debounce #(
            .W          (IN_W),
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clock   (clock),
            .resetn  (resetn),
            .din     (in_port[g*IN_W +: IN_W]),
            .dout    (deb_s[g*IN_W +: IN_W]),
            .changed (chg_s[g])
        );
    end

    // Output registers, one per port.
    for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
        logic [31:0] out_r;
        logic        hit_s;

        assign hit_s = wr_s && (idx_s == bank_idx(IDX_OUT, g));

        // Output register k: load on a store to its index.
        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                out_r <= 32'h0000_0000;
            end else if (hit_s) begin
                out_r <= bus.wdata;
            end else begin
                out_r <= out_r;
            end
        end

        assign out_port[g*32 +: 32] = out_r;
    end

    // STATUS clear mask and IEN write strobe from the current store.
    always_comb begin
        if (wr_s && (idx_s == IDX_STATUS)) begin
            clr_s = bus.wdata[NUM_IN-1:0];
        end else begin
            clr_s = {NUM_IN{1'b0}};
        end
        ien_wr_s = wr_s && (idx_s == IDX_IEN);
    end

    // STATUS flags: a debounce change on the same edge as a clear keeps the flag.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            status_r <= {NUM_IN{1'b0}};
        end else begin
            status_r <= (status_r & ~clr_s) | chg_s;
        end
    end

    // Interrupt enable register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ien_r <= {NUM_IN{1'b0}};
        end else if (ien_wr_s) begin
            ien_r <= bus.wdata[NUM_IN-1:0];
        end else begin
            ien_r <= ien_r;
        end
    end

    // Level interrupt, one clock behind STATUS/IEN.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= |(status_r & ien_r);
        end
    end

    assign irq = irq_r;

    // Read mux: each register contributes only when its index matches, so
    // unmapped indices fall out as zero.
    always_comb begin
        rd_s = 32'h0000_0000;
        for (int k = 0; k < NUM_IN; k++) begin
            rd_s = rd_s | ({32{idx_s == bank_idx(IDX_IN, k)}}
                           & 32'(deb_s[k*IN_W +: IN_W]));
        end
        for (int k = 0; k < NUM_OUT; k++) begin
            rd_s = rd_s | ({32{idx_s == bank_idx(IDX_OUT, k)}}
                           & out_port[k*32 +: 32]);
        end
        rd_s = rd_s | ({32{idx_s == IDX_STATUS}} & 32'(status_r));
        rd_s = rd_s | ({32{idx_s == IDX_IEN}} & 32'(ien_r));
        if (io_sel_s) begin
            bus.rdata = rd_s;
        end else begin
            bus.rdata = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_io_port_bank.sv
// -----------------------------------------------------------------------------
// tb_io_port_bank
// Directed scenarios plus randomized traffic for io_port_bank
// (NUM_IN=2, IN_W=4, NUM_OUT=3, DEB_CYCLES=4). A reference model keeps the
// last input samples in a history array and applies the debounce rule
// "value sampled two edges ago, constant over the last DEB_CYCLES samples,
// and different from the current debounced value".
// -----------------------------------------------------------------------------
module tb_io_port_bank;
    import io_pkg::*;

    localparam int NUM_IN     = 2;
    localparam int IN_W       = 4;
    localparam int NUM_OUT    = 3;
    localparam int DEB_CYCLES = 4;

    localparam logic [31:0] CHK_ADDRS [7] = '{32'h80, 32'h84, 32'hA0, 32'hA4,
                                              32'hA8, 32'hC0, 32'hC4};
    localparam logic [31:0] RND_ADDRS [13] = '{32'h80, 32'h84, 32'hA0, 32'hA4,
                                               32'hA8, 32'hAC, 32'hC0, 32'hC4,
                                               32'hC8, 32'hD0, 32'h40, 32'h24,
                                               32'h00};

    logic                   clock = 1'b0;
    logic                   resetn;
    logic [NUM_IN*IN_W-1:0] in_port;
    logic [NUM_OUT*32-1:0]  out_port;
    logic                   irq;

    io_port_bank_if bus ();

    io_port_bank #(
        .NUM_IN     (NUM_IN),
        .IN_W       (IN_W),
        .NUM_OUT    (NUM_OUT),
        .DEB_CYCLES (DEB_CYCLES)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .bus      (bus),
        .in_port  (in_port),
        .out_port (out_port),
        .irq      (irq)
    );

    always #10 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    logic [IN_W-1:0]        m_in [NUM_IN];
    logic [NUM_IN-1:0]      m_status;
    logic [NUM_IN-1:0]      m_ien;
    logic [31:0]            m_out [NUM_OUT];
    logic                   m_irq;
    logic [NUM_IN*IN_W-1:0] hist [0:DEB_CYCLES];   // hist[DEB_CYCLES] = newest sample

    function automatic logic settles(input int k);
        logic [IN_W-1:0] v;
        v = hist[0][k*IN_W +: IN_W];
        for (int i = 1; i < DEB_CYCLES; i++) begin
            if (hist[i][k*IN_W +: IN_W] != v) return 1'b0;
        end
        return v != m_in[k];
    endfunction

    function automatic logic [NUM_IN-1:0] settle_mask();
        logic [NUM_IN-1:0] m;
        m = '0;
        for (int k = 0; k < NUM_IN; k++) m[k] = settles(k);
        return m;
    endfunction

    function automatic logic is_wr(input int idx);
        return bus.we && bus.addr[7] && (int'(bus.addr[6:2]) == idx);
    endfunction

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < NUM_IN; k++) m_in[k] <= '0;
            for (int k = 0; k < NUM_OUT; k++) m_out[k] <= '0;
            for (int i = 0; i <= DEB_CYCLES; i++) hist[i] <= '0;
            m_status <= '0;
            m_ien    <= '0;
            m_irq    <= 1'b0;
        end else begin
            m_irq    <= |(m_status & m_ien);
            m_status <= (m_status & ~(is_wr(int'(IDX_STATUS)) ? bus.wdata[NUM_IN-1:0] : 2'b00))
                        | settle_mask();
            for (int k = 0; k < NUM_IN; k++) begin
                if (settles(k)) m_in[k] <= hist[0][k*IN_W +: IN_W];
            end
            for (int i = 0; i < DEB_CYCLES; i++) hist[i] <= hist[i+1];
            hist[DEB_CYCLES] <= in_port;
            if (is_wr(int'(IDX_IEN))) m_ien <= bus.wdata[NUM_IN-1:0];
            for (int k = 0; k < NUM_OUT; k++) begin
                if (is_wr(int'(IDX_OUT) + k)) m_out[k] <= bus.wdata;
            end
        end
    end

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        int idx;
        idx = int'(a[6:2]);
        if (!a[7]) return 32'h0;
        if (idx < NUM_IN) return 32'(m_in[idx]);
        if (idx >= int'(IDX_OUT) && idx < int'(IDX_OUT) + NUM_OUT) return m_out[idx - int'(IDX_OUT)];
        if (idx == int'(IDX_STATUS)) return 32'(m_status);
        if (idx == int'(IDX_IEN)) return 32'(m_ien);
        return 32'h0;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] sa;
        logic [31:0] sw;
        logic        swe;
        check_eq("out_port", out_port, {m_out[2], m_out[1], m_out[0]});
        check_eq("irq", 96'(irq), 96'(m_irq));
        sa  = bus.addr;
        sw  = bus.wdata;
        swe = bus.we;
        bus.we = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.addr = CHK_ADDRS[i];
            #1;
            check_eq($sformatf("rd_%0h", CHK_ADDRS[i]), 96'(bus.rdata), 96'(exp_read(CHK_ADDRS[i])));
        end
        bus.addr  = sa;
        bus.wdata = sw;
        bus.we    = swe;
    endtask

    task automatic cycle();
        @(posedge clock);
        #2;
        check_all();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.we   = 1'b0;
        bus.addr = a;
        #1;
        d = bus.rdata;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.we    = 1'b1;
        cycle();
        bus.we    = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] d;
        bus.addr  = 32'h0;
        bus.wdata = 32'h0;
        bus.we    = 1'b0;
        in_port   = 8'hFF;
        resetn    = 1'b0;

        // Reset with inputs held high.
        cycles(2);
        check_eq("rst_out_port", out_port, 96'h0);
        check_eq("rst_irq", 96'(irq), 96'h0);
        rd(32'h80, d);
        check_eq("rst_in0", 96'(d), 96'h0);

        // Release: IN0 becomes 0xF on the 6th edge, not before.
        resetn = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            cycle();
            rd(32'h80, d);
            check_eq($sformatf("rel_in0_e%0d", e), 96'(d), (e == 6) ? 96'hF : 96'h0);
        end
        rd(32'hC0, d);
        check_eq("rel_status", 96'(d), 96'h3);
        wr(32'hC0, 32'h3);

        // Debounce 0 -> 5 on port 0.
        in_port = 8'hF0;
        cycles(8);
        wr(32'hC0, 32'h3);
        in_port = 8'hF5;
        for (int e = 1; e <= 6; e++) begin
            cycle();
            rd(32'h80, d);
            check_eq($sformatf("deb_in0_e%0d", e), 96'(d), (e == 6) ? 96'h5 : 96'h0);
        end
        wr(32'hC0, 32'h3);

        // 3-clock glitch to 0xA is ignored.
        in_port = 8'hFA;
        cycles(3);
        in_port = 8'hF5;
        cycles(10);
        rd(32'h80, d);
        check_eq("glitch_in0", 96'(d), 96'h5);
        rd(32'hC0, d);
        check_eq("glitch_status", 96'(d), 96'h0);

        // Output register write and aliased (io_sel=0) write.
        wr(32'hA4, 32'hDEADBEEF);
        check_eq("out1_write", 96'(out_port[63:32]), 96'hDEADBEEF);
        rd(32'hA4, d);
        check_eq("out1_read", 96'(d), 96'hDEADBEEF);
        wr(32'h24, 32'h12345678);
        check_eq("alias_write", out_port, {32'h0, 32'hDEADBEEF, 32'h0});

        // Interrupt: only IN0 enabled.
        wr(32'hC4, 32'h1);
        in_port = 8'h35;
        cycles(7);
        rd(32'hC0, d);
        check_eq("irq_status_in1", 96'(d), 96'h2);
        check_eq("irq_in1_masked", 96'(irq), 96'h0);
        in_port = 8'h36;
        cycles(6);
        rd(32'hC0, d);
        check_eq("irq_status_both", 96'(d), 96'h3);
        check_eq("irq_not_yet", 96'(irq), 96'h0);
        cycle();
        check_eq("irq_set", 96'(irq), 96'h1);
        wr(32'hC0, 32'h1);
        rd(32'hC0, d);
        check_eq("irq_w1c_status", 96'(d), 96'h2);
        cycle();
        check_eq("irq_cleared", 96'(irq), 96'h0);

        // Collision: W1C of STATUS[0] on the debounce edge.
        in_port = 8'h37;
        cycles(5);
        bus.addr  = 32'hC0;
        bus.wdata = 32'h1;
        bus.we    = 1'b1;
        cycle();
        bus.we = 1'b0;
        rd(32'hC0, d);
        check_eq("collision_status", 96'(d), 96'h3);

        // Unmapped reads and writes.
        rd(32'h8C, d);
        check_eq("unmapped_idx3", 96'(d), 96'h0);
        rd(32'h48, d);
        check_eq("unmapped_iosel0", 96'(d), 96'h0);
        wr(32'hD0, 32'hFFFFFFFF);
        check_eq("idx20_out", out_port, {32'h0, 32'hDEADBEEF, 32'h0});
        rd(32'hC0, d);
        check_eq("idx20_status", 96'(d), 96'h3);
        rd(32'hC4, d);
        check_eq("idx20_ien", 96'(d), 96'h1);

        // Reset mid-debounce leaves no residue.
        in_port = 8'h00;
        cycles(3);
        resetn = 1'b0;
        #1;
        check_eq("midrst_out", out_port, 96'h0);
        check_eq("midrst_irq", 96'(irq), 96'h0);
        cycles(2);
        resetn = 1'b1;
        cycles(8);
        rd(32'h80, d);
        check_eq("midrst_in0", 96'(d), 96'h0);
        rd(32'hC0, d);
        check_eq("midrst_status", 96'(d), 96'h0);

        // Randomized traffic checked every cycle against the model.
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 9) == 0) in_port = 8'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                bus.addr  = RND_ADDRS[$urandom_range(0, 12)];
                bus.wdata = $urandom;
                bus.we    = 1'b1;
            end else begin
                bus.we = 1'b0;
            end
            if ($urandom_range(0, 299) == 0) resetn = 1'b0;
            else resetn = 1'b1;
            cycle();
        end
        bus.we = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_port_bank.md
IO_PORT_BANK -- requirements
Module: io_port_bank

Interface
REQ-001 SHALL have parameter NUM_IN, default 2: number of input ports (1..8).
REQ-002 SHALL have parameter IN_W, default 4: width of each input port (1..32).
REQ-003 SHALL have parameter NUM_OUT, default 3: number of 32-bit output ports (1..8).
REQ-004 SHALL have parameter DEB_CYCLES, default 16: debounce stability length in clocks (2..65535).
REQ-005 SHALL have port clock, input, 1: sole clock; all state changes on its rising edge.
REQ-006 SHALL have port resetn, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port addr, input, 32: CPU byte address; io_sel = addr[7]; register index = addr[6:2].
REQ-008 SHALL have port wdata, input, 32: CPU store data.
REQ-009 SHALL have port we, input, 1: store strobe; the write takes effect only when io_sel=1.
REQ-010 SHALL have port rdata, output, 32: combinational read data for the addressed register.
REQ-011 SHALL have port in_port, input, NUM_IN*IN_W: raw asynchronous switch/key inputs; port k occupies bits [k*IN_W +: IN_W].
REQ-012 SHALL have port out_port, output, NUM_OUT*32: output registers; port k occupies bits [k*32 +: 32].
REQ-013 SHALL have port irq, output, 1: registered level interrupt to the CPU.

Function
REQ-014 Register map (index): 0..NUM_IN-1 IN[k] (RO, zero-extended debounced value); 8..8+NUM_OUT-1 OUT[k] (RW); 16 STATUS (bit k = change flag of IN[k], W1C); 17 IEN (bits NUM_IN-1:0, RW); all other indices read 0 and ignore writes.
REQ-015 rdata SHALL be 0 when io_sel=0; otherwise it SHALL be the addressed register, with no clock latency.
REQ-016 Each input bit SHALL pass through a 2-flop synchroniser before any other use.
REQ-017 Each port SHALL have a stability counter that clears whenever the synchronised value differs from its previous sample, and otherwise increments, saturating at DEB_CYCLES-1.
REQ-018 Debounced IN[k] SHALL load the synchronised value on the edge where that value differs from IN[k] and has been unchanged for DEB_CYCLES consecutive edges; a single stable input change is therefore visible in IN[k] exactly 2+DEB_CYCLES clocks later.
REQ-019 Glitches shorter than DEB_CYCLES clocks SHALL never change IN[k] or set STATUS.
REQ-020 STATUS[k] SHALL set on the same edge that IN[k] changes value.
REQ-021 Writing 1 to STATUS[k] SHALL clear it; writing 0 SHALL have no effect; when a set and a clear occur on the same edge, set SHALL win.
REQ-022 OUT[k] SHALL load wdata on the edge where we=1, io_sel=1 and index=8+k; otherwise it SHALL hold its value.
REQ-023 irq SHALL equal the previous cycle's OR of (STATUS & IEN), i.e. one clock of latency after STATUS or IEN changes.
REQ-024 The counter width SHALL be $clog2(DEB_CYCLES); no counter SHALL wrap.

Reset
REQ-025 While resetn=0, the block SHALL asynchronously force the following and hold them until release:
- synchronisers, debounced IN, counters, STATUS, IEN, irq all 0;
- OUT[k] = 0.
REQ-026 After resetn rises, inputs already held high SHALL produce IN=value and set STATUS after 2+DEB_CYCLES clocks, like any other change.
REQ-027 A reset asserted mid-debounce SHALL discard the partial count, with no residual effect after release.

Structure
REQ-028 Register index constants (IDX_IN=0, IDX_OUT=8, IDX_STATUS=16, IDX_IEN=17) SHALL live in the shared package io_pkg.
REQ-029 The per-port synchroniser, counter and debounced register SHALL be one sub-module, io_debounce (param W, DEB_CYCLES), instantiated NUM_IN times via generate.
REQ-030 The block SHALL drop into sc_datamem in place of the fixed two-in/three-out port logic, with no change to the CPU.

Verification (NUM_IN=2, IN_W=4, NUM_OUT=3, DEB_CYCLES=4)
REQ-031 Reset: resetn=0 with in_port=8'hFF -> out_port=0, rdata@0x80=0, irq=0; release -> IN0 reads 0xF at the 6th edge after release, not before.
REQ-032 Debounce: in_port[3:0] changes 0->5 -> IN0 reads 5 exactly 6 clocks later; a 3-clock pulse to 0xA -> IN0 stays 5, STATUS stays 0.
REQ-033 Output write: we=1, addr=0x000000A4, wdata=0xDEADBEEF -> out_port[63:32]=0xDEADBEEF next edge; a read at 0xA4 returns 0xDEADBEEF; a write with addr=0x24 leaves all OUT unchanged.
REQ-034 Interrupt: IEN=0x1, IN1 changes -> STATUS=0x2, irq stays 0; IN0 changes -> STATUS=0x3, irq=1 one clock later; write 0x1 to 0xC0 -> STATUS=0x2, irq=0 next clock.
REQ-035 Collision: STATUS[0] W1C on the same edge that IN0 debounces -> STATUS[0] remains 1.
REQ-036 Unmapped: read at 0x8C (index 3) and at 0x48 (io_sel=0) -> 0; write 0xFFFFFFFF to index 20 -> no register changes.
